// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with Mealy match flag and optional saturating match counter.
// Optional feature macro: SEQ_DETECT_CNT_EN builds the match counter; otherwise cnt is tied to zero.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             i_vld,
    input  logic             clr,
    output logic             q,
    output logic [SW-1:0]    pst,
    output logic [CNT_W-1:0] cnt
);

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
            $error("seq_detect_param: PAT_LEN must lie in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("seq_detect_param: CNT_W must lie in 1..32");
        end
    endgenerate

    localparam int            NS   = 2 ** SW;
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

    // Longest prefix of PATTERN (shorter than the whole pattern) that ends the
    // string "first s pattern bits followed by b"; a completed match falls back
    // to the border of the full pattern, or to 0 when overlaps are not counted.
    function automatic logic [SW-1:0] calc_next(input int s, input int b);
        int   best;
        int   len;
        int   idx;
        logic ok;
        logic sb;
        len  = s + 1;
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int m = 0; m < k; m++) begin
                    idx = len - k + m;
                    sb  = (idx == s) ? b[0] : PATTERN[PAT_LEN-1-idx];
                    if (sb != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        if (s == PAT_LEN - 1 && b[0] == PATTERN[0] && OVERLAP == 0) best = 0;
        return SW'(best);
    endfunction

    // Entry {state, bit} holds the successor; unused state encodings stay 0.
    function automatic logic [2*NS*SW-1:0] build_nxt();
        logic [2*NS*SW-1:0] t;
        t = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                t[(2*s+b)*SW +: SW] = calc_next(s, b);
            end
        end
        return t;
    endfunction

    localparam logic [2*NS*SW-1:0] NXT_TBL = build_nxt();

    logic [SW-1:0] pst_nxt;
    logic          hit;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
        pst_nxt = pst;
        hit     = 1'b0;
        if (clr) begin
            pst_nxt = '0;
        end else if (i_vld) begin
            hit     = (pst == LAST) && (i == PATTERN[0]);
            pst_nxt = NXT_TBL[SW*int'({pst, i}) +: SW];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pst <= '0;
        end else begin
            pst <= pst_nxt;
        end
    end

    assign q = rst & hit;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating: once all ones, further matches are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (hit && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign cnt = cnt_r;
`else
    assign cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default, non-overlapping and 2-bit counter instances share one stimulus stream.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic       i_vld;
    logic       clr;
    logic       q_a, q_b, q_c;
    logic [1:0] pst_a, pst_b, pst_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       qa_s, qb_s, qc_s;

    int checks = 0;
    int errors = 0;

    seq_detect_param dut_a (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .clr(clr),
        .q(q_a), .pst(pst_a), .cnt(cnt_a)
    );

    seq_detect_param #(.OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .clr(clr),
        .q(q_b), .pst(pst_b), .cnt(cnt_b)
    );

    seq_detect_param #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .i(i), .i_vld(i_vld), .clr(clr),
        .q(q_c), .pst(pst_c), .cnt(cnt_c)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ce(input int x);
        return CNT_ON ? x : 0;
    endfunction

    // Drive one cycle on the falling edge, capture the Mealy flags before the
    // rising edge, then return just after the rising edge.
    task automatic step(input logic b, input logic v, input logic c);
        @(negedge clk);
        i     = b;
        i_vld = v;
        clr   = c;
        #1;
        qa_s = q_a;
        qb_s = q_b;
        qc_s = q_c;
        @(posedge clk);
        #1;
    endtask

    // Alternating stream 1,0,1,0,... twelve bits
    int   s2_pa [12] = '{1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 2};
    int   s2_pb [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    logic s2_qa [12] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic s2_qb [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int   s2_ca [12] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    int   s2_cb [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    int   s2_cc [12] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};

    // Stream 1,1,0,0,1,0,1,0
    logic s3_b  [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
    int   s3_pa [8] = '{1, 1, 2, 0, 1, 2, 3, 2};
    int   s3_pb [8] = '{1, 1, 2, 0, 1, 2, 3, 0};
    logic s3_q  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    // Valid gaps with toggling data, including a gap while one bit from completion
    logic s4_b  [8] = '{1, 0, 1, 0, 1, 1, 0, 0};
    logic s4_v  [8] = '{1, 1, 0, 0, 0, 1, 0, 1};
    int   s4_pa [8] = '{1, 2, 2, 2, 2, 3, 3, 2};
    int   s4_pb [8] = '{1, 2, 2, 2, 2, 3, 3, 0};
    logic s4_q  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst   = 1'b0;
        i     = 1'b1;
        i_vld = 1'b1;
        clr   = 1'b0;
        #3;
        check("reset pst_a", 32'(pst_a), 0);
        check("reset cnt_a", 32'(cnt_a), 0);
        check("reset q_a", 32'(q_a), 0);
        @(negedge clk);
        i_vld = 1'b0;
        rst   = 1'b1;

        for (int n = 0; n < 12; n++) begin
            step(~n[0], 1'b1, 1'b0);
            check($sformatf("alt q_a[%0d]", n), 32'(qa_s), 32'(s2_qa[n]));
            check($sformatf("alt pst_a[%0d]", n), 32'(pst_a), s2_pa[n]);
            check($sformatf("alt q_b[%0d]", n), 32'(qb_s), 32'(s2_qb[n]));
            check($sformatf("alt pst_b[%0d]", n), 32'(pst_b), s2_pb[n]);
            check($sformatf("alt q_c[%0d]", n), 32'(qc_s), 32'(s2_qa[n]));
            check($sformatf("alt cnt_a[%0d]", n), 32'(cnt_a), ce(s2_ca[n]));
            check($sformatf("alt cnt_b[%0d]", n), 32'(cnt_b), ce(s2_cb[n]));
            check($sformatf("alt cnt_c[%0d]", n), 32'(cnt_c), ce(s2_cc[n]));
        end

        step(1'b0, 1'b0, 1'b1);
        check("clr pst_a", 32'(pst_a), 0);
        check("clr cnt_a", 32'(cnt_a), 0);
        check("clr cnt_c", 32'(cnt_c), 0);

        for (int n = 0; n < 8; n++) begin
            step(s3_b[n], 1'b1, 1'b0);
            check($sformatf("mix q_a[%0d]", n), 32'(qa_s), 32'(s3_q[n]));
            check($sformatf("mix pst_a[%0d]", n), 32'(pst_a), s3_pa[n]);
            check($sformatf("mix q_b[%0d]", n), 32'(qb_s), 32'(s3_q[n]));
            check($sformatf("mix pst_b[%0d]", n), 32'(pst_b), s3_pb[n]);
        end
        check("mix cnt_a", 32'(cnt_a), ce(1));

        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step(s4_b[n], s4_v[n], 1'b0);
            check($sformatf("gap q_a[%0d]", n), 32'(qa_s), 32'(s4_q[n]));
            check($sformatf("gap pst_a[%0d]", n), 32'(pst_a), s4_pa[n]);
            check($sformatf("gap pst_b[%0d]", n), 32'(pst_b), s4_pb[n]);
            check($sformatf("gap cnt_a[%0d]", n), 32'(cnt_a), ce(int'(s4_q[n])));
        end

        step(1'b1, 1'b1, 1'b0);
        check("pre-rst pst_a", 32'(pst_a), 3);
        check("pre-rst cnt_a", 32'(cnt_a), ce(1));
        #1;
        i     = 1'b0;
        i_vld = 1'b1;
        rst   = 1'b0;
        #1;
        check("async rst pst_a", 32'(pst_a), 0);
        check("async rst cnt_a", 32'(cnt_a), 0);
        check("async rst q_a", 32'(q_a), 0);
        rst = 1'b1;

        step(1'b1, 1'b1, 1'b0);
        check("post-rst pst_a", 32'(pst_a), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre-clr pst_a", 32'(pst_a), 3);
        step(1'b0, 1'b1, 1'b1);
        check("clr+hit q_a", 32'(qa_s), 0);
        check("clr+hit pst_a", 32'(pst_a), 0);
        check("clr+hit cnt_a", 32'(cnt_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
